// File: rtl/pkt_proc_enq_arbiter.sv
// Round-robin arbiter that gives one packet source at a time the pkt_proc enqueue port, for a whole packet.
// Optional stall watchdog with forced-eop abort and drain: define PKT_ARB_WDOG_EN.
module pkt_proc_enq_arbiter #(
    parameter int NUM_SRC  = 4,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 12,
    parameter int WDOG_CYC = 64
) (
    input  logic                      pck_proc_int_mem_fsm_clk,
    input  logic                      pck_proc_int_mem_fsm_rstn,
    input  logic                      pck_proc_int_mem_fsm_sw_rstn,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC-1:0]        src_eop,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC*LEN_W-1:0]  src_len,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic                      pck_proc_full,
    input  logic                      pck_proc_almost_full,
    output logic                      enq_req,
    output logic                      in_sop,
    output logic                      in_eop,
    output logic [DATA_W-1:0]         wr_data_i,
    output logic                      pck_len_valid,
    output logic [LEN_W-1:0]          pck_len_i,
    output logic [NUM_SRC-1:0]        grant_vec,
    output logic                      len_err,
    output logic                      arb_timeout
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
`ifdef PKT_ARB_WDOG_EN
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam int         SCNT_W = $clog2(WDOG_CYC + 1);
`endif

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               enq_q, enq_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic               lenv_q, lenv_d;
    logic               lerr_q, lerr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [LEN_W-1:0]   plen_q, plen_d;
    logic [NUM_SRC-1:0] ready_c;
`ifdef PKT_ARB_WDOG_EN
    logic [SCNT_W-1:0]  stall_q, stall_d;
    logic               tout_q, tout_d;
`endif

    logic [IDX_W-1:0]   pick, cand;
    logic               found;
    logic               cur_valid, cur_eop, acc;
    logic [DATA_W-1:0]  cur_data;

    // Scan starts one past the last grant so every source gets a turn.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            cand = IDX_W'((32'(last_q) + i) % NUM_SRC);
            if (!found && src_valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign cur_valid = src_valid[gidx_q];
    assign cur_eop   = src_eop[gidx_q];
    assign cur_data  = src_data[gidx_q*DATA_W +: DATA_W];
    assign acc       = (state_q == XFER) && cur_valid && !pck_proc_full;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        enq_d   = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        lenv_d  = 1'b0;
        lerr_d  = 1'b0;
        data_d  = data_q;
        plen_d  = plen_q;
        ready_c = '0;
`ifdef PKT_ARB_WDOG_EN
        stall_d = stall_q;
        tout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|src_valid && !pck_proc_almost_full) begin
                    gidx_d  = pick;
                    last_d  = pick;
                    grant_d = NUM_SRC'(1) << pick;
                    len_d   = src_len[pick*LEN_W +: LEN_W];
                    cnt_d   = '0;
                    first_d = 1'b1;
                    state_d = XFER;
`ifdef PKT_ARB_WDOG_EN
                    stall_d = '0;
`endif
                end
            end
            XFER: begin
                if (!pck_proc_full) ready_c[gidx_q] = 1'b1;
                if (acc) begin
                    enq_d   = 1'b1;
                    sop_d   = first_q;
                    lenv_d  = first_q;
                    eop_d   = cur_eop;
                    data_d  = cur_data;
                    plen_d  = len_q;
                    first_d = 1'b0;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);
                    if (cur_eop) begin
                        lerr_d  = ({1'b0, cnt_q} + (LEN_W+1)'(1)) != {1'b0, len_q};
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
`ifdef PKT_ARB_WDOG_EN
                // Full-blocked cycles hold the count; the abort itself ignores full.
                if (acc) begin
                    stall_d = '0;
                end else if (!cur_valid) begin
                    if (stall_q == SCNT_W'(WDOG_CYC - 1)) begin
                        enq_d   = 1'b1;
                        eop_d   = 1'b1;
                        sop_d   = first_q;
                        lenv_d  = first_q;
                        data_d  = '0;
                        plen_d  = len_q;
                        first_d = 1'b0;
                        tout_d  = 1'b1;
                        stall_d = '0;
                        state_d = DRAIN;
                    end else if (!pck_proc_full) begin
                        stall_d = stall_q + SCNT_W'(1);
                    end
                end
`endif
            end
`ifdef PKT_ARB_WDOG_EN
            DRAIN: begin
                ready_c[gidx_q] = 1'b1;
                if (cur_valid && cur_eop) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Soft reset forces the same values as the async reset on the next edge.
        if (!pck_proc_int_mem_fsm_sw_rstn) begin
            state_d = IDLE;
            last_d  = IDX_W'(NUM_SRC - 1);
            gidx_d  = '0;
            grant_d = '0;
            len_d   = '0;
            cnt_d   = '0;
            first_d = 1'b0;
            enq_d   = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            lenv_d  = 1'b0;
            lerr_d  = 1'b0;
            data_d  = '0;
            plen_d  = '0;
            ready_c = '0;
`ifdef PKT_ARB_WDOG_EN
            stall_d = '0;
            tout_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge pck_proc_int_mem_fsm_clk or negedge pck_proc_int_mem_fsm_rstn) begin
        if (!pck_proc_int_mem_fsm_rstn) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_SRC - 1);
            gidx_q  <= '0;
            grant_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            enq_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            lenv_q  <= 1'b0;
            lerr_q  <= 1'b0;
            data_q  <= '0;
            plen_q  <= '0;
`ifdef PKT_ARB_WDOG_EN
            stall_q <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            enq_q   <= enq_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            lenv_q  <= lenv_d;
            lerr_q  <= lerr_d;
            data_q  <= data_d;
            plen_q  <= plen_d;
`ifdef PKT_ARB_WDOG_EN
            stall_q <= stall_d;
            tout_q  <= tout_d;
`endif
        end
    end

    assign src_ready     = ready_c;
    assign enq_req       = enq_q;
    assign in_sop        = sop_q;
    assign in_eop        = eop_q;
    assign wr_data_i     = data_q;
    assign pck_len_valid = lenv_q;
    assign pck_len_i     = plen_q;
    assign grant_vec     = grant_q;
    assign len_err       = lerr_q;
`ifdef PKT_ARB_WDOG_EN
    assign arb_timeout   = tout_q;
`else
    assign arb_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_proc_enq_arbiter.sv
// Directed bench for pkt_proc_enq_arbiter: per-cycle vector table plus hand sequences
// for backpressure, length error, async reset and (with PKT_ARB_WDOG_EN) the watchdog.
module tb_pkt_proc_enq_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         sw_rstn;
    logic [3:0]   src_valid;
    logic [3:0]   src_eop;
    logic [127:0] src_data;
    logic [47:0]  src_len;
    logic [3:0]   src_ready;
    logic         full;
    logic         afull;
    logic         enq_req, in_sop, in_eop, pck_len_valid, len_err, arb_timeout;
    logic [31:0]  wr_data_i;
    logic [11:0]  pck_len_i;
    logic [3:0]   grant_vec;

    int n_pass = 0;
    int n_tot  = 0;

    pkt_proc_enq_arbiter #(
        .NUM_SRC (4),
        .DATA_W  (32),
        .LEN_W   (12),
        .WDOG_CYC(8)
    ) dut (
        .pck_proc_int_mem_fsm_clk    (clk),
        .pck_proc_int_mem_fsm_rstn   (rst_n),
        .pck_proc_int_mem_fsm_sw_rstn(sw_rstn),
        .src_valid                   (src_valid),
        .src_eop                     (src_eop),
        .src_data                    (src_data),
        .src_len                     (src_len),
        .src_ready                   (src_ready),
        .pck_proc_full               (full),
        .pck_proc_almost_full        (afull),
        .enq_req                     (enq_req),
        .in_sop                      (in_sop),
        .in_eop                      (in_eop),
        .wr_data_i                   (wr_data_i),
        .pck_len_valid               (pck_len_valid),
        .pck_len_i                   (pck_len_i),
        .grant_vec                   (grant_vec),
        .len_err                     (len_err),
        .arb_timeout                 (arb_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  e;
        logic [7:0]  tag;
        logic [11:0] len;
        logic        full;
        logic        afull;
        logic        srst;
        logic [3:0]  x_rdy;
        logic        x_enq;
        logic        x_sop;
        logic        x_eop;
        logic [31:0] x_data;
        logic [3:0]  x_gnt;
        logic        x_lerr;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] e, input logic [7:0] tag,
                                input logic [11:0] len, input logic fl, input logic af, input logic sr,
                                input logic [3:0] rdy, input logic enq, input logic sop, input logic eop,
                                input logic [31:0] data, input logic [3:0] gnt, input logic lerr);
        vec_t r;
        r.v = v; r.e = e; r.tag = tag; r.len = len; r.full = fl; r.afull = af; r.srst = sr;
        r.x_rdy = rdy; r.x_enq = enq; r.x_sop = sop; r.x_eop = eop; r.x_data = data;
        r.x_gnt = gnt; r.x_lerr = lerr;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Source i presents (i<<8)|tag; all sources share one length.
    task automatic set_src(input logic [3:0] v, input logic [3:0] e, input logic [7:0] tag,
                           input logic [11:0] len);
        src_valid = v;
        src_eop   = e;
        for (int i = 0; i < 4; i++) begin
            src_data[i*32 +: 32] = (32'(i) << 8) | 32'(tag);
            src_len[i*12 +: 12]  = len;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got, b, cyc;
        logic acc;
        logic exp_enq;

        rst_n = 1'b0; sw_rstn = 1'b1; full = 1'b0; afull = 1'b0;
        set_src(4'b0000, 4'b0000, 8'h00, 12'd0);
        #1;
        chk("rst.enq", 32'(enq_req), 32'd0);
        chk("rst.gnt", 32'(grant_vec), 32'd0);
        chk("rst.data", wr_data_i, 32'd0);
        chk("rst.sop_eop_lv", {29'd0, in_sop, in_eop, pck_len_valid}, 32'd0);
        chk("rst.err_to", {30'd0, len_err, arb_timeout}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst.rdy", 32'(src_ready), 32'd0);

        // T1: src0/src2 3-beat packets
        tbl[0]  = mk(4'b0101, 4'b0000, 8'd1, 12'd3, 0, 0, 0, 4'b0000, 0, 0, 0, 32'h000, 4'b0001, 0);
        tbl[1]  = mk(4'b0101, 4'b0000, 8'd1, 12'd3, 0, 0, 0, 4'b0001, 1, 1, 0, 32'h001, 4'b0001, 0);
        tbl[2]  = mk(4'b0101, 4'b0000, 8'd2, 12'd3, 0, 0, 0, 4'b0001, 1, 0, 0, 32'h002, 4'b0001, 0);
        tbl[3]  = mk(4'b0101, 4'b0001, 8'd3, 12'd3, 0, 0, 0, 4'b0001, 1, 0, 1, 32'h003, 4'b0000, 0);
        tbl[4]  = mk(4'b0100, 4'b0000, 8'd1, 12'd3, 0, 0, 0, 4'b0000, 0, 0, 0, 32'h000, 4'b0100, 0);
        tbl[5]  = mk(4'b0100, 4'b0000, 8'd1, 12'd3, 0, 0, 0, 4'b0100, 1, 1, 0, 32'h201, 4'b0100, 0);
        tbl[6]  = mk(4'b0100, 4'b0000, 8'd2, 12'd3, 0, 0, 0, 4'b0100, 1, 0, 0, 32'h202, 4'b0100, 0);
        tbl[7]  = mk(4'b0100, 4'b0100, 8'd3, 12'd3, 0, 0, 0, 4'b0100, 1, 0, 1, 32'h203, 4'b0000, 0);
        tbl[8]  = mk(4'b0000, 4'b0000, 8'd0, 12'd3, 0, 0, 0, 4'b0000, 0, 0, 0, 32'h000, 4'b0000, 0);
        // soft reset restores last_grant so src0 wins, then T2 1-beat round robin
        tbl[9]  = mk(4'b1111, 4'b1111, 8'd5, 12'd1, 0, 0, 1, 4'b0000, 0, 0, 0, 32'h000, 4'b0000, 0);
        tbl[10] = mk(4'b1111, 4'b1111, 8'd5, 12'd1, 0, 0, 0, 4'b0000, 0, 0, 0, 32'h000, 4'b0001, 0);
        tbl[11] = mk(4'b1111, 4'b1111, 8'd5, 12'd1, 0, 0, 0, 4'b0001, 1, 1, 1, 32'h005, 4'b0000, 0);
        tbl[12] = mk(4'b1111, 4'b1111, 8'd5, 12'd1, 0, 0, 0, 4'b0000, 0, 0, 0, 32'h000, 4'b0010, 0);
        tbl[13] = mk(4'b1111, 4'b1111, 8'd5, 12'd1, 0, 0, 0, 4'b0010, 1, 1, 1, 32'h105, 4'b0000, 0);
        tbl[14] = mk(4'b1111, 4'b1111, 8'd5, 12'd1, 0, 0, 0, 4'b0000, 0, 0, 0, 32'h000, 4'b0100, 0);
        tbl[15] = mk(4'b1111, 4'b1111, 8'd5, 12'd1, 0, 0, 0, 4'b0100, 1, 1, 1, 32'h205, 4'b0000, 0);
        tbl[16] = mk(4'b1111, 4'b1111, 8'd5, 12'd1, 0, 0, 0, 4'b0000, 0, 0, 0, 32'h000, 4'b1000, 0);
        tbl[17] = mk(4'b1111, 4'b1111, 8'd5, 12'd1, 0, 0, 0, 4'b1000, 1, 1, 1, 32'h305, 4'b0000, 0);
        tbl[18] = mk(4'b1111, 4'b1111, 8'd5, 12'd1, 0, 0, 0, 4'b0000, 0, 0, 0, 32'h000, 4'b0001, 0);
        tbl[19] = mk(4'b1111, 4'b1111, 8'd5, 12'd1, 0, 0, 0, 4'b0001, 1, 1, 1, 32'h005, 4'b0000, 0);
        // T4: almost_full blocks grant in IDLE but not an ongoing beat
        tbl[20] = mk(4'b0010, 4'b0010, 8'd7, 12'd1, 0, 1, 0, 4'b0000, 0, 0, 0, 32'h000, 4'b0000, 0);
        tbl[21] = mk(4'b0010, 4'b0010, 8'd7, 12'd1, 0, 1, 0, 4'b0000, 0, 0, 0, 32'h000, 4'b0000, 0);
        tbl[22] = mk(4'b0010, 4'b0010, 8'd7, 12'd1, 0, 0, 0, 4'b0000, 0, 0, 0, 32'h000, 4'b0010, 0);
        tbl[23] = mk(4'b0010, 4'b0010, 8'd7, 12'd1, 0, 1, 0, 4'b0010, 1, 1, 1, 32'h107, 4'b0000, 0);
        // short packet against len=2 -> len_err for exactly one cycle
        tbl[24] = mk(4'b0001, 4'b0000, 8'd8, 12'd2, 0, 0, 0, 4'b0000, 0, 0, 0, 32'h000, 4'b0001, 0);
        tbl[25] = mk(4'b0001, 4'b0001, 8'd8, 12'd2, 0, 0, 0, 4'b0001, 1, 1, 1, 32'h008, 4'b0000, 1);
        tbl[26] = mk(4'b0000, 4'b0000, 8'd0, 12'd2, 0, 0, 0, 4'b0000, 0, 0, 0, 32'h000, 4'b0000, 0);

        for (int k = 0; k < 27; k++) begin
            set_src(tbl[k].v, tbl[k].e, tbl[k].tag, tbl[k].len);
            full    = tbl[k].full;
            afull   = tbl[k].afull;
            sw_rstn = !tbl[k].srst;
            #1;
            chk($sformatf("v%0d.rdy", k), 32'(src_ready), 32'(tbl[k].x_rdy));
            tick();
            chk($sformatf("v%0d.enq", k), 32'(enq_req), 32'(tbl[k].x_enq));
            chk($sformatf("v%0d.sop", k), 32'(in_sop), 32'(tbl[k].x_sop));
            chk($sformatf("v%0d.lenv", k), 32'(pck_len_valid), 32'(tbl[k].x_sop));
            chk($sformatf("v%0d.eop", k), 32'(in_eop), 32'(tbl[k].x_eop));
            chk($sformatf("v%0d.gnt", k), 32'(grant_vec), 32'(tbl[k].x_gnt));
            chk($sformatf("v%0d.lerr", k), 32'(len_err), 32'(tbl[k].x_lerr));
            chk($sformatf("v%0d.tout", k), 32'(arb_timeout), 32'd0);
            if (tbl[k].x_enq) begin
                chk($sformatf("v%0d.data", k), wr_data_i, tbl[k].x_data);
                chk($sformatf("v%0d.plen", k), 32'(pck_len_i), 32'(tbl[k].len));
            end
        end
        sw_rstn = 1'b1;

        // T3: src1 6-beat packet, full high for 5 cycles mid-packet
        set_src(4'b0010, 4'b0000, 8'h00, 12'd6);
        src_data[32 +: 32] = 32'hA0;
        tick();
        chk("t3.gnt", 32'(grant_vec), 32'b0010);
        got = 0; b = 0; cyc = 0;
        while (got < 6 && cyc < 40) begin
            full = (cyc >= 2 && cyc < 7);
            src_valid[1] = (b < 6);
            src_eop[1]   = (b == 5);
            src_data[32 +: 32] = 32'hA0 + 32'(b);
            #1;
            chk($sformatf("t3.c%0d.rdy", cyc), 32'(src_ready), full ? 32'd0 : 32'b0010);
            acc = src_valid[1] & src_ready[1];
            exp_enq = acc;
            tick();
            if (acc) b++;
            chk($sformatf("t3.c%0d.enq", cyc), 32'(enq_req), 32'(exp_enq));
            if (enq_req) begin
                chk($sformatf("t3.b%0d.data", got), wr_data_i, 32'hA0 + 32'(got));
                chk($sformatf("t3.b%0d.sop", got), 32'(in_sop), 32'(got == 0));
                chk($sformatf("t3.b%0d.eop", got), 32'(in_eop), 32'(got == 5));
                if (got == 5) chk("t3.lerr", 32'(len_err), 32'd0);
                got++;
            end
            cyc++;
        end
        full = 1'b0;
        chk("t3.beats", 32'(got), 32'd6);
        chk("t3.gnt_rel", 32'(grant_vec), 32'd0);

        // T5: src3 len=4 ends after 2 beats
        set_src(4'b1000, 4'b0000, 8'hC1, 12'd4);
        tick();
        chk("t5.gnt", 32'(grant_vec), 32'b1000);
        #1;
        chk("t5.rdy", 32'(src_ready), 32'b1000);
        tick();
        chk("t5.b1.enq", 32'(enq_req), 32'd1);
        chk("t5.b1.data", wr_data_i, 32'h3C1);
        chk("t5.b1.lerr", 32'(len_err), 32'd0);
        set_src(4'b1000, 4'b1000, 8'hC2, 12'd4);
        tick();
        chk("t5.b2.eop", 32'(in_eop), 32'd1);
        chk("t5.b2.lerr", 32'(len_err), 32'd1);
        chk("t5.b2.gnt", 32'(grant_vec), 32'd0);
        set_src(4'b0000, 4'b0000, 8'h00, 12'd4);
        tick();
        chk("t5.after.lerr", 32'(len_err), 32'd0);
        chk("t5.after.enq", 32'(enq_req), 32'd0);

        // Async reset mid-packet of src1, then src0 must win over src1/src2
        set_src(4'b0010, 4'b0000, 8'hD1, 12'd3);
        tick();
        chk("ar.gnt", 32'(grant_vec), 32'b0010);
        tick();
        chk("ar.enq", 32'(enq_req), 32'd1);
        set_src(4'b0111, 4'b0000, 8'hD2, 12'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.enq0", 32'(enq_req), 32'd0);
        chk("ar.gnt0", 32'(grant_vec), 32'd0);
        chk("ar.data0", wr_data_i, 32'd0);
        chk("ar.rdy0", 32'(src_ready), 32'd0);
        chk("ar.sop_eop_lv0", {29'd0, in_sop, in_eop, pck_len_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar.first", 32'(grant_vec), 32'b0001);

`ifdef PKT_ARB_WDOG_EN
        // T6: src0 stalls 8 cycles after beat 1 -> forced eop, then drain
        set_src(4'b0001, 4'b0000, 8'hB1, 12'd5);
        tick();
        chk("t6.b1.enq", 32'(enq_req), 32'd1);
        chk("t6.b1.data", wr_data_i, 32'h0B1);
        set_src(4'b0000, 4'b0000, 8'h00, 12'd5);
        for (int i = 0; i < 8; i++) begin
            full = (i == 7);
            tick();
            if (i < 7) begin
                chk($sformatf("t6.s%0d.enq", i), 32'(enq_req), 32'd0);
                chk($sformatf("t6.s%0d.tout", i), 32'(arb_timeout), 32'd0);
            end
        end
        chk("t6.f.enq", 32'(enq_req), 32'd1);
        chk("t6.f.eop", 32'(in_eop), 32'd1);
        chk("t6.f.sop", 32'(in_sop), 32'd0);
        chk("t6.f.data", wr_data_i, 32'd0);
        chk("t6.f.tout", 32'(arb_timeout), 32'd1);
        chk("t6.f.lerr", 32'(len_err), 32'd0);
        chk("t6.f.gnt", 32'(grant_vec), 32'b0001);
        set_src(4'b0001, 4'b0000, 8'hB2, 12'd5);
        #1;
        chk("t6.d.rdy", 32'(src_ready), 32'b0001);
        tick();
        chk("t6.d1.enq", 32'(enq_req), 32'd0);
        chk("t6.d1.tout", 32'(arb_timeout), 32'd0);
        chk("t6.d1.gnt", 32'(grant_vec), 32'b0001);
        full = 1'b0;
        set_src(4'b0001, 4'b0001, 8'hB3, 12'd5);
        tick();
        chk("t6.d2.enq", 32'(enq_req), 32'd0);
        chk("t6.d2.gnt", 32'(grant_vec), 32'd0);
        set_src(4'b0010, 4'b0000, 8'h00, 12'd5);
        tick();
        chk("t6.next.gnt", 32'(grant_vec), 32'b0010);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
